// File: rtl/gate_tt_sequencer_if.sv
// Purpose : bundles the control/result handshake and the GUT stimulus/response pins of gate_tt_sequencer.
// Latency : none, plain wires.
// Backpressure: none; start is a level sampled by the sequencer only while idle.
//   start     : begin a run (slave -> master)
//   gate_out  : GUT response (slave -> master)
//   gate_in   : vector driven to the GUT, bit 0 = LSB input (master -> slave)
//   busy/done/pass/err_cnt/fail_vec : run status and results (master -> slave)
interface gate_tt_sequencer_if #(
  parameter int N_IN = 2
);
  logic            start;
  logic            gate_out;
  logic [N_IN-1:0] gate_in;
  logic            busy;
  logic            done;
  logic            pass;
  logic [N_IN:0]   err_cnt;
  logic [N_IN-1:0] fail_vec;

  // Sequencer side.
  modport master (
    input  start, gate_out,
    output gate_in, busy, done, pass, err_cnt, fail_vec
  );

  // Control / GUT side.
  modport slave (
    output start, gate_out,
    input  gate_in, busy, done, pass, err_cnt, fail_vec
  );
endinterface

// File: rtl/gate_tt_sequencer.sv
// Purpose : walks every input vector of a small combinational GUT and checks its output against EXP_TT.
// Latency : start sampled in cycle T gives done in cycle T+1+2^N_IN*(SETTLE_CYC+1).
// Backpressure: none; start is only accepted in IDLE and is dropped (not queued) otherwise.
//   clk, rst : single clock, synchronous active-high reset
//   bus      : gate_tt_sequencer_if.master (start/gate_out in; gate_in/busy/done/pass/err_cnt/fail_vec out)
module gate_tt_sequencer #(
  parameter int                    N_IN       = 2,
  parameter int                    SETTLE_CYC = 5,
  parameter logic [(1<<N_IN)-1:0]  EXP_TT     = 4'b1000
) (
  input  logic                clk,
  input  logic                rst,
  gate_tt_sequencer_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_CHECK  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // A settle time of 1 needs a counter that only ever holds 0; keep it one bit wide.
  localparam int              CW       = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE_CYC - 1);
  localparam logic [N_IN:0]   ERR_MAX  = (N_IN + 1)'(1 << N_IN);
  localparam logic [N_IN-1:0] IDX_LAST = '1;

  logic [1:0]      state;
  logic [N_IN-1:0] idx;
  logic [CW-1:0]   cnt;
  logic            busy_q;
  logic            done_q;
  logic            pass_q;
  logic [N_IN:0]   err_cnt_q;
  logic [N_IN-1:0] fail_vec_q;
  logic            first_fail;
  logic            mismatch;

  // Only consulted in CHECK, so anything the GUT does while settling is irrelevant.
  assign mismatch = (bus.gate_out != EXP_TT[idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      idx        <= '0;
      cnt        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_cnt_q  <= '0;
      fail_vec_q <= '0;
      first_fail <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state      <= S_SETTLE;
            idx        <= '0;
            cnt        <= CNT_LOAD;
            busy_q     <= 1'b1;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            fail_vec_q <= '0;
            first_fail <= 1'b0;
          end
        end
        S_SETTLE: begin
          if (cnt == '0) begin
            state <= S_CHECK;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            if (err_cnt_q != ERR_MAX) begin
              err_cnt_q <= err_cnt_q + (N_IN + 1)'(1);
            end
            if (!first_fail) begin
              fail_vec_q <= idx;
              first_fail <= 1'b1;
            end
          end
          if (idx == IDX_LAST) begin
            // done and pass are registered here so both are visible in the DONE cycle;
            // pass has to fold in the verdict of this final vector.
            state  <= S_DONE;
            done_q <= 1'b1;
            pass_q <= (err_cnt_q == '0) && !mismatch;
          end else begin
            idx   <= idx + N_IN'(1);
            cnt   <= CNT_LOAD;
            state <= S_SETTLE;
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // gate_in is the vector index itself; it therefore holds all ones after a run.
  assign bus.gate_in  = idx;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.pass     = pass_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.fail_vec = fail_vec_q;

endmodule

// File: tb/tb_gate_tt_sequencer.sv
// Bench for gate_tt_sequencer: two instances (SETTLE_CYC=5 and SETTLE_CYC=1) each driving a
// behavioural GUT whose function is chosen per run from a vector table.
module tb_gate_tt_sequencer;

  logic clk;
  logic rst;

  gate_tt_sequencer_if #(.N_IN(2)) bus_a ();
  gate_tt_sequencer_if #(.N_IN(2)) bus_b ();

  gate_tt_sequencer #(.N_IN(2), .SETTLE_CYC(5), .EXP_TT(4'b1000)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  gate_tt_sequencer #(.N_IN(2), .SETTLE_CYC(1), .EXP_TT(4'b1000)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // GUT modes: 0 AND, 1 OR, 2 tied 0, 3 tied 1,
  // 4 AND only inside the check cycle and inverted otherwise (settle-time glitches).
  int   gut_mode;
  logic chk_win;
  int   dut_sel;

  function automatic logic gut(input int m, input logic [1:0] v, input logic win);
    case (m)
      0:       return v[0] & v[1];
      1:       return v[0] | v[1];
      2:       return 1'b0;
      3:       return 1'b1;
      default: return win ? (v[0] & v[1]) : ~(v[0] & v[1]);
    endcase
  endfunction

  assign bus_a.gate_out = gut(gut_mode, bus_a.gate_in, chk_win && dut_sel == 0);
  assign bus_b.gate_out = gut(gut_mode, bus_b.gate_in, chk_win && dut_sel == 1);

  logic       cur_busy, cur_done, cur_pass;
  logic [2:0] cur_err;
  logic [1:0] cur_fail, cur_gin;

  always_comb begin
    cur_busy = bus_a.busy;
    cur_done = bus_a.done;
    cur_pass = bus_a.pass;
    cur_err  = bus_a.err_cnt;
    cur_fail = bus_a.fail_vec;
    cur_gin  = bus_a.gate_in;
    if (dut_sel == 1) begin
      cur_busy = bus_b.busy;
      cur_done = bus_b.done;
      cur_pass = bus_b.pass;
      cur_err  = bus_b.err_cnt;
      cur_fail = bus_b.fail_vec;
      cur_gin  = bus_b.gate_in;
    end
  end

  typedef struct {
    logic [2:0] err;
    logic [1:0] fv;
    logic       pass;
  } res_t;

  typedef struct {
    int         dsel;
    int         mode;
    bit         repulse;
    logic [2:0] exp_err;
    logic [1:0] exp_fail;
    logic       exp_pass;
  } vec_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_start(input logic v);
    if (dut_sel == 1) bus_b.start = v;
    else              bus_a.start = v;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"},  cur_busy, 0);
    chk({tag, "_done"},  cur_done, 0);
    chk({tag, "_pass"},  cur_pass, 0);
    chk({tag, "_err"},   cur_err,  0);
    chk({tag, "_fail"},  cur_fail, 0);
    chk({tag, "_gin"},   cur_gin,  0);
  endtask

  // One full run: start at cycle 0, per-cycle checks of gate_in/busy/done, scoreboard on done.
  task automatic run_row(input vec_t r);
    int   hold;
    int   last;
    res_t e;
    res_t got;
    dut_sel  = r.dsel;
    gut_mode = r.mode;
    hold     = (r.dsel == 1) ? 2 : 6;
    last     = 4 * hold + 1;
    e.err  = r.exp_err;
    e.fv   = r.exp_fail;
    e.pass = r.exp_pass;
    sb.push_back(e);
    @(negedge clk);
    set_start(1'b1);
    for (int k = 1; k <= last + 2; k++) begin
      @(negedge clk);
      chk_win = (k <= 4 * hold) && (k % hold == 0);
      set_start(r.repulse && (k == 3 || k == last));
      chk("gate_in", cur_gin, (k <= 4 * hold) ? (k - 1) / hold : 3);
      chk("busy", cur_busy, (k <= last) ? 1 : 0);
      chk("done", cur_done, (k == last) ? 1 : 0);
      if (k == 1) begin
        chk("clr_pass", cur_pass, 0);
        chk("clr_err",  cur_err,  0);
        chk("clr_fail", cur_fail, 0);
      end
      if (cur_done === 1'b1 && sb.size() != 0) begin
        got = sb.pop_front();
        chk("pass",     cur_pass, got.pass);
        chk("err_cnt",  cur_err,  got.err);
        chk("fail_vec", cur_fail, got.fv);
      end
    end
    chk_win = 1'b0;
    set_start(1'b0);
    chk("done_seen", sb.size(), 0);
    sb.delete();
    chk("hold_pass", cur_pass, r.exp_pass);
    chk("hold_err",  cur_err,  r.exp_err);
    chk("hold_fail", cur_fail, r.exp_fail);
  endtask

  vec_t tbl[9];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //           dsel mode rep err fv pass
    tbl[0] = '{0, 0, 1'b0, 3'd0, 2'd0, 1'b1};  // AND
    tbl[1] = '{0, 1, 1'b0, 3'd2, 2'd1, 1'b0};  // OR
    tbl[2] = '{0, 2, 1'b0, 3'd1, 2'd3, 1'b0};  // tied 0
    tbl[3] = '{0, 3, 1'b0, 3'd3, 2'd0, 1'b0};  // tied 1
    tbl[4] = '{0, 0, 1'b1, 3'd0, 2'd0, 1'b1};  // AND, start re-pulsed at 3 and in DONE
    tbl[5] = '{1, 0, 1'b0, 3'd0, 2'd0, 1'b1};  // SETTLE_CYC=1, AND
    tbl[6] = '{1, 1, 1'b0, 3'd2, 2'd1, 1'b0};  // SETTLE_CYC=1, OR
    tbl[7] = '{0, 4, 1'b0, 3'd0, 2'd0, 1'b1};  // glitches outside check cycle
    tbl[8] = '{1, 4, 1'b0, 3'd0, 2'd0, 1'b1};

    rst         = 1'b1;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    gut_mode    = 0;
    chk_win     = 1'b0;
    dut_sel     = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst_a");
    dut_sel = 1;
    chk_reset_vals("rst_b");
    rst = 1'b0;

    foreach (tbl[i]) run_row(tbl[i]);

    // rst mid-run (tied-1 GUT so err_cnt and gate_in are non-zero when it hits).
    dut_sel  = 0;
    gut_mode = 3;
    @(negedge clk);
    set_start(1'b1);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      set_start(1'b0);
      if (k == 10) begin
        chk("pre_rst_err", cur_err, 1);
        rst = 1'b1;
      end
    end
    @(negedge clk);
    chk_reset_vals("midrst");
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("midrst_idle_busy", cur_busy, 0);
      chk("midrst_no_done",   cur_done, 0);
    end
    run_row(tbl[0]);

    // rst and start on the same edge: reset wins and the start is lost.
    dut_sel = 0;
    @(negedge clk);
    rst = 1'b1;
    set_start(1'b1);
    @(negedge clk);
    rst = 1'b0;
    set_start(1'b0);
    chk_reset_vals("rst_start");
    repeat (2) begin
      @(negedge clk);
      chk("rst_start_busy", cur_busy, 0);
      chk("rst_start_gin",  cur_gin,  0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
